// File: rtl/snitch_ro_cache_ctrl.sv
// Runtime control for snitch_read_only_cache: enable/flush/rule registers, outstanding-read
// tracking and a drain-flush-apply sequence. Optional PERF counter: SNITCH_RO_CACHE_CTRL_PERF_EN.
module snitch_ro_cache_ctrl #(
   parameter int unsigned NrAddrRules  = 1,
   parameter int unsigned AxiAddrWidth = 48,
   parameter int unsigned MaxTrans     = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                cfg_req_valid_i,
   output logic                                cfg_req_ready_o,
   input  logic                                cfg_req_write_i,
   input  logic [7:0]                          cfg_req_addr_i,
   input  logic [31:0]                         cfg_req_wdata_i,
   output logic                                cfg_rsp_valid_o,
   output logic [31:0]                         cfg_rsp_rdata_o,
   output logic                                cfg_rsp_error_o,
   input  logic                                ar_valid_i,
   input  logic                                ar_ready_i,
   input  logic                                r_valid_i,
   input  logic                                r_ready_i,
   input  logic                                r_last_i,
   output logic                                ar_hold_o,
   output logic                                enable_o,
   output logic                                flush_valid_o,
   input  logic                                flush_ready_i,
   output logic [NrAddrRules*AxiAddrWidth-1:0] start_addr_o,
   output logic [NrAddrRules*AxiAddrWidth-1:0] end_addr_o
);
   localparam int unsigned CntW = $clog2(MaxTrans + 1);
   localparam int unsigned HiW  = AxiAddrWidth - 32;

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, APPLY} state_e;
   state_e state;

   logic [AxiAddrWidth-1:0] shd_start [NrAddrRules];
   logic [AxiAddrWidth-1:0] shd_end   [NrAddrRules];
   logic                    ctrl_en, err, err_set;
   logic [CntW-1:0]         cnt;
   logic                    wr, wr_ctrl, wr_status, trigger, ctrl_en_nxt;
   logic                    ar_hs, r_done, rd_err;
   logic [31:0]             rd_data;

   assign cfg_req_ready_o = 1'b1;
   assign wr          = cfg_req_valid_i & cfg_req_write_i;
   assign wr_ctrl     = wr && (cfg_req_addr_i == 8'h00);
   assign wr_status   = wr && (cfg_req_addr_i == 8'h04);
   assign trigger     = wr_ctrl & (cfg_req_wdata_i[1] | cfg_req_wdata_i[2]);
   assign ctrl_en_nxt = wr_ctrl ? cfg_req_wdata_i[0] : ctrl_en;
   assign ar_hs       = ar_valid_i & ar_ready_i;
   assign r_done      = r_valid_i & r_ready_i & r_last_i;
   assign err_set     = (ar_hs & ~r_done & (cnt == CntW'(MaxTrans)))
                      | (r_done & ~ar_hs & (cnt == '0));

`ifdef SNITCH_RO_CACHE_CTRL_PERF_EN
   logic [31:0] perf_cnt;
   logic        wr_perf;
   assign wr_perf = wr && (cfg_req_addr_i == 8'h08);

   always_ff @(posedge clk_i) begin
      if (rst_i || wr_perf) perf_cnt <= '0;
      else if (state != IDLE && perf_cnt != 32'hFFFF_FFFF) perf_cnt <= perf_cnt + 32'd1;
   end
`endif

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      if (cfg_req_addr_i[1:0] != 2'b00) begin
         rd_err = 1'b1;
      end else if (cfg_req_addr_i[7:4] == 4'h0) begin
         case (cfg_req_addr_i[3:2])
            2'd0: rd_data[0] = ctrl_en;
            2'd1: begin
               rd_data[0]         = (state != IDLE);
               rd_data[1]         = err;
               rd_data[8 +: CntW] = cnt;
            end
`ifdef SNITCH_RO_CACHE_CTRL_PERF_EN
            2'd2: rd_data = perf_cnt;
`else
            2'd2: rd_data = '0;
`endif
            default: rd_err = 1'b1;
         endcase
      end else begin
         rd_err = 1'b1;
         for (int i = 0; i < NrAddrRules; i++) begin
            if (cfg_req_addr_i[7:4] == 4'(i + 1)) begin
               rd_err = 1'b0;
               case (cfg_req_addr_i[3:2])
                  2'd0:    rd_data            = shd_start[i][31:0];
                  2'd1:    rd_data[HiW-1:0]   = shd_start[i][AxiAddrWidth-1:32];
                  2'd2:    rd_data            = shd_end[i][31:0];
                  default: rd_data[HiW-1:0]   = shd_end[i][AxiAddrWidth-1:32];
               endcase
            end
         end
      end
   end

   // Register port: response is registered, exactly one cycle after the request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_rsp_valid_o <= 1'b0;
         cfg_rsp_rdata_o <= '0;
         cfg_rsp_error_o <= 1'b0;
         ctrl_en         <= 1'b0;
         for (int i = 0; i < NrAddrRules; i++) begin
            shd_start[i] <= '0;
            shd_end[i]   <= '0;
         end
      end else begin
         cfg_rsp_valid_o <= cfg_req_valid_i;
         cfg_rsp_rdata_o <= (cfg_req_valid_i && !cfg_req_write_i) ? rd_data : '0;
         cfg_rsp_error_o <= cfg_req_valid_i & rd_err;
         ctrl_en         <= ctrl_en_nxt;
         for (int i = 0; i < NrAddrRules; i++) begin
            if (wr && cfg_req_addr_i[1:0] == 2'b00 && cfg_req_addr_i[7:4] == 4'(i + 1)) begin
               case (cfg_req_addr_i[3:2])
                  2'd0:    shd_start[i][31:0]              <= cfg_req_wdata_i;
                  2'd1:    shd_start[i][AxiAddrWidth-1:32] <= cfg_req_wdata_i[HiW-1:0];
                  2'd2:    shd_end[i][31:0]                <= cfg_req_wdata_i;
                  default: shd_end[i][AxiAddrWidth-1:32]   <= cfg_req_wdata_i[HiW-1:0];
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (ar_hs && !r_done && cnt != CntW'(MaxTrans)) cnt <= cnt + 1'b1;
         else if (r_done && !ar_hs && cnt != '0)       cnt <= cnt - 1'b1;
         // A new error in the same cycle as a clear wins, so nothing is lost.
         err <= (err & ~(wr_status & cfg_req_wdata_i[1])) | err_set;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         ar_hold_o     <= 1'b0;
         enable_o      <= 1'b0;
         flush_valid_o <= 1'b0;
         start_addr_o  <= '0;
         end_addr_o    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  state     <= DRAIN;
                  ar_hold_o <= 1'b1;
                  enable_o  <= 1'b0;
               end else begin
                  enable_o  <= ctrl_en_nxt;
               end
            end
            DRAIN: begin
               if (cnt == '0 && !ar_hs) begin
                  state         <= FLUSH;
                  flush_valid_o <= 1'b1;
               end
            end
            FLUSH: begin
               // New rules are loaded as APPLY is entered so the cache sees them in APPLY.
               if (flush_ready_i) begin
                  state         <= APPLY;
                  flush_valid_o <= 1'b0;
                  for (int i = 0; i < NrAddrRules; i++) begin
                     start_addr_o[i*AxiAddrWidth +: AxiAddrWidth] <= shd_start[i];
                     end_addr_o[i*AxiAddrWidth +: AxiAddrWidth]   <= shd_end[i];
                  end
               end
            end
            default: begin
               state     <= IDLE;
               ar_hold_o <= 1'b0;
               enable_o  <= ctrl_en_nxt;
            end
         endcase
      end
   end
endmodule
